// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: turns each retiring MIPS instruction into a trace record drained through a valid/ready FIFO
module retire_trace_buffer #(
  parameter int DEPTH = 8,
  parameter bit FILTER_DEFAULT = 1'b0
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     filter,
  input  logic [31:0]              pc,
  input  logic [31:0]              inst,
  input  logic [31:0]              WD3,
  input  logic [31:0]              ALUresult,
  input  logic [31:0]              WriteDataMem,
  input  logic                     RegWrite,
  input  logic                     MemWrite,
  input  logic                     BEQ,
  input  logic                     BNE,
  input  logic                     zero,
  input  logic                     jump,
  input  logic                     JR,
  input  logic                     JAL,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [1:0]               out_kind,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [31:0]              retired_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem_pc [DEPTH];
  logic [31:0] mem_inst [DEPTH];
  logic [31:0] mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [1:0] mem_kind [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [1:0] kind;
  logic [31:0] rec_addr, rec_data;
  logic xfer, push_req, full, pop, push, unused;
  assign unused = JAL;
  // classify the retiring instruction and resolve push/pop for this edge
  always_comb begin
    xfer = jump | JR | (BEQ & zero) | (BNE & ~zero);
    kind = MemWrite ? 2'd2 : RegWrite ? 2'd1 : xfer ? 2'd3 : 2'd0;
    rec_addr = (kind == 2'd2) ? ALUresult : '0;
    rec_data = (kind == 2'd2) ? WriteDataMem : (kind == 2'd1) ? WD3 : '0;
    push_req = enable & (~(filter ^ FILTER_DEFAULT) | (kind != 2'd0));
    full = fill[AW];
    pop = out_valid & out_ready;
    push = push_req & (~full | pop);
  end
  // record storage; slots outside the live window are never shown since out_* are masked by out_valid
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_pc[wptr] <= pc;
      mem_inst[wptr] <= inst;
      mem_addr[wptr] <= rec_addr;
      mem_data[wptr] <= rec_data;
      mem_kind[wptr] <= kind;
    end
  end
  // pointers, occupancy, drop tracking and retirement count
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
      fill <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      retired_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      fill <= fill + (AW+1)'(push) - (AW+1)'(pop);
      if (push_req & full & ~pop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (enable) retired_cnt <= retired_cnt + 32'd1;
    end
  end
  // head-of-queue view, forced to zero while empty
  always_comb begin
    out_valid = fill != '0;
    out_pc = out_valid ? mem_pc[rptr] : '0;
    out_inst = out_valid ? mem_inst[rptr] : '0;
    out_addr = out_valid ? mem_addr[rptr] : '0;
    out_data = out_valid ? mem_data[rptr] : '0;
    out_kind = out_valid ? mem_kind[rptr] : '0;
  end
endmodule

// File: tb/tb_retire_trace_buffer.sv
// tb_retire_trace_buffer: scoreboard bench for the retire trace buffer
module tb_retire_trace_buffer;
  localparam int DEPTH = 8;
  localparam bit FD = 1'b0;
  localparam logic [7:0] C_NOP = 8'h00, C_RW = 8'h80, C_SW = 8'h40, C_BEQ = 8'h20, C_BNE = 8'h10;
  localparam logic [7:0] C_Z = 8'h08, C_J = 8'h04, C_JR = 8'h02, C_JAL = 8'h01;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0] kind;
  } rec_t;
  logic CLK = 0, reset = 1, enable = 0, filter = 0, out_ready = 0;
  logic [31:0] pc = 0, inst = 0, WD3 = 0, ALUresult = 0, WriteDataMem = 0;
  logic RegWrite = 0, MemWrite = 0, BEQ = 0, BNE = 0, zero = 0, jump = 0, JR = 0, JAL = 0;
  logic out_valid, overflow;
  logic [31:0] out_pc, out_inst, out_addr, out_data, retired_cnt;
  logic [1:0] out_kind;
  logic [3:0] fill;
  logic [15:0] drop_cnt;
  rec_t q[$];
  int m_ret, m_drop, n_cmp, n_bad;
  logic g_pop, g_epop;
  rec_t g_act, g_exp;

  retire_trace_buffer #(.DEPTH(DEPTH), .FILTER_DEFAULT(FD)) dut (
    .CLK(CLK), .reset(reset), .enable(enable), .filter(filter),
    .pc(pc), .inst(inst), .WD3(WD3), .ALUresult(ALUresult), .WriteDataMem(WriteDataMem),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .BEQ(BEQ), .BNE(BNE), .zero(zero),
    .jump(jump), .JR(JR), .JAL(JAL),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_addr(out_addr), .out_data(out_data), .out_kind(out_kind), .fill(fill),
    .overflow(overflow), .drop_cnt(drop_cnt), .retired_cnt(retired_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic rec_t model_rec();
    rec_t r;
    r.pc = pc;
    r.inst = inst;
    if (MemWrite) r.kind = 2'd2;
    else if (RegWrite) r.kind = 2'd1;
    else if (jump || JR || (BEQ && zero) || (BNE && !zero)) r.kind = 2'd3;
    else r.kind = 2'd0;
    r.addr = (r.kind == 2'd2) ? ALUresult : 32'd0;
    r.data = (r.kind == 2'd2) ? WriteDataMem : (r.kind == 2'd1) ? WD3 : 32'd0;
    return r;
  endfunction

  task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic [31:0] w,
                       input logic [31:0] a, input logic [31:0] d, input logic [7:0] c);
    pc = p; inst = i; WD3 = w; ALUresult = a; WriteDataMem = d;
    {RegWrite, MemWrite, BEQ, BNE, zero, jump, JR, JAL} = c;
  endtask

  task automatic tick();
    rec_t r;
    logic pr;
    r = model_rec();
    pr = enable && (!(filter ^ FD) || r.kind != 2'd0);
    g_pop = out_valid & out_ready;
    g_act = g_pop ? rec_t'({out_pc, out_inst, out_addr, out_data, out_kind}) : rec_t'('0);
    g_epop = (q.size() != 0) && out_ready;
    g_exp = '0;
    if (g_epop) g_exp = q.pop_front();
    if (pr) begin
      if (q.size() < DEPTH) q.push_back(r);
      else m_drop++;
    end
    if (enable) m_ret++;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; out_ready = 1;
    drive(32'h10, 32'h20080001, 32'h5, 32'h5, 32'h0, C_RW);
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if ({out_valid, fill, overflow, drop_cnt, retired_cnt, out_pc, out_inst, out_addr, out_data, out_kind} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b fill=%0d ovf=%b drop=%0d ret=%0d pc=%h want all zero",
               out_valid, fill, overflow, drop_cnt, retired_cnt, out_pc);
    end
    reset = 0;
    q.delete(); m_ret = 0; m_drop = 0;
  endtask

  task automatic test_addi();
    filter = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      enable = (k < 3);
      drive(32'(4 * k), 32'h20080001 + 32'(k), 32'h100 + 32'(k), 32'h100 + 32'(k), 32'h0, C_RW);
      tick();
      n_cmp++;
      if ({g_pop, g_act} !== {g_epop, g_exp}) begin
        n_bad++;
        $display("FAIL addi_rec%0d: got %b/%h want %b/%h", k, g_pop, g_act, g_epop, g_exp);
      end
      n_cmp++;
      if (fill > 4'd1) begin
        n_bad++;
        $display("FAIL addi_fill%0d: got %0d want <=1", k, fill);
      end
    end
    n_cmp++;
    if (retired_cnt !== 32'd3) begin
      n_bad++;
      $display("FAIL addi_retired: got %0d want 3", retired_cnt);
    end
  endtask

  task automatic test_store_filter();
    filter = 1; enable = 1; out_ready = 1;
    drive(32'h20, 32'hAC090000, 32'h1234, 32'h40, 32'hDEADBEEF, C_SW);
    tick();
    n_cmp++;
    if ({g_pop, g_act} !== {g_epop, g_exp}) begin
      n_bad++;
      $display("FAIL sw_push: got %b/%h want %b/%h", g_pop, g_act, g_epop, g_exp);
    end
    drive(32'h24, 32'h0, 32'h0, 32'h0, 32'h0, C_NOP);
    tick();
    n_cmp++;
    if ({g_pop, g_act} !== {1'b1, rec_t'({32'h20, 32'hAC090000, 32'h40, 32'hDEADBEEF, 2'd2})}) begin
      n_bad++;
      $display("FAIL sw_record: got %b/%h want 1/sw kind2 addr 40 data deadbeef", g_pop, g_act);
    end
    enable = 0;
    tick();
    n_cmp++;
    if ({g_pop, fill} !== {1'b0, 4'd0}) begin
      n_bad++;
      $display("FAIL nop_filtered: got pop=%b fill=%0d want pop=0 fill=0", g_pop, fill);
    end
  endtask

  task automatic test_branch();
    logic [7:0] pat [6];
    pat = '{C_BEQ, C_BEQ | C_Z, C_BNE, C_BNE | C_Z, C_RW | C_JAL, C_J};
    filter = 1; out_ready = 1;
    for (int k = 0; k < 7; k++) begin
      enable = (k < 6);
      drive(32'h80 + 32'(4 * k), 32'h10000000 + 32'(k), 32'h84 + 32'(4 * k), 32'h0, 32'h0, (k < 6) ? pat[k] : C_NOP);
      tick();
      n_cmp++;
      if ({g_pop, g_act} !== {g_epop, g_exp}) begin
        n_bad++;
        $display("FAIL branch_rec%0d: got %b/%h want %b/%h", k, g_pop, g_act, g_epop, g_exp);
      end
    end
    n_cmp++;
    if (fill !== 4'd0) begin
      n_bad++;
      $display("FAIL branch_drained: got fill=%0d want 0", fill);
    end
  endtask

  task automatic test_overflow();
    filter = 0; enable = 1; out_ready = 0;
    for (int k = 0; k < 11; k++) begin
      drive(32'h100 + 32'(4 * k), 32'h0, 32'h0, 32'h0, 32'h0, C_NOP);
      tick();
    end
    n_cmp++;
    if ({fill, drop_cnt, overflow} !== {4'd8, 16'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL overflow_state: got fill=%0d drop=%0d ovf=%b want fill=8 drop=3 ovf=1", fill, drop_cnt, overflow);
    end
  endtask

  task automatic test_full_pushpop();
    enable = 1; out_ready = 1; filter = 0;
    drive(32'h200, 32'h0, 32'h0, 32'h0, 32'h0, C_NOP);
    tick();
    n_cmp++;
    if ({g_pop, g_act.pc} !== {1'b1, 32'h100}) begin
      n_bad++;
      $display("FAIL full_pushpop_head: got pop=%b pc=%h want pop=1 pc=00000100", g_pop, g_act.pc);
    end
    n_cmp++;
    if ({fill, drop_cnt} !== {4'd8, 16'd3}) begin
      n_bad++;
      $display("FAIL full_pushpop_fill: got fill=%0d drop=%0d want fill=8 drop=3", fill, drop_cnt);
    end
    enable = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_cmp++;
      if ({g_pop, g_act.pc} !== {1'b1, (k < 7) ? 32'h104 + 32'(4 * k) : 32'h200}) begin
        n_bad++;
        $display("FAIL drain%0d: got pop=%b pc=%h want pop=1 in-order pc", k, g_pop, g_act.pc);
      end
      n_cmp++;
      if ({g_pop, g_act} !== {g_epop, g_exp}) begin
        n_bad++;
        $display("FAIL drain_rec%0d: got %b/%h want %b/%h", k, g_pop, g_act, g_epop, g_exp);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    enable = 1; out_ready = 0; filter = 0;
    for (int k = 0; k < 6; k++) begin
      drive(32'h300 + 32'(4 * k), 32'h0, 32'h7, 32'h0, 32'h0, C_RW);
      tick();
    end
    enable = 0; out_ready = 1;
    tick();
    n_cmp++;
    if (fill !== 4'd5) begin
      n_bad++;
      $display("FAIL mid_drain_fill: got %0d want 5", fill);
    end
    reset = 1;
    #1;
    n_cmp++;
    if ({out_valid, fill, overflow, retired_cnt, drop_cnt, out_pc} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b fill=%0d ovf=%b ret=%0d drop=%0d pc=%h want all zero",
               out_valid, fill, overflow, retired_cnt, drop_cnt, out_pc);
    end
    @(posedge CLK);
    #1;
    reset = 0;
    q.delete(); m_ret = 0; m_drop = 0;
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      enable = (k < 48) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      filter = 1'($urandom_range(0, 1));
      out_ready = (k < 48) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      drive(32'h1000 + 32'(4 * k), $urandom, $urandom, $urandom, $urandom, 8'($urandom));
      tick();
      n_cmp++;
      if ({g_pop, g_act} !== {g_epop, g_exp}) begin
        n_bad++;
        $display("FAIL b2b_rec%0d: got %b/%h want %b/%h", k, g_pop, g_act, g_epop, g_exp);
      end
    end
    n_cmp++;
    if ({fill, retired_cnt, drop_cnt} !== {4'(q.size()), 32'(m_ret), 16'(m_drop)}) begin
      n_bad++;
      $display("FAIL b2b_counters: got fill=%0d ret=%0d drop=%0d want fill=%0d ret=%0d drop=%0d",
               fill, retired_cnt, drop_cnt, q.size(), m_ret, m_drop);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_store_filter();
    test_branch();
    test_overflow();
    test_full_pushpop();
    test_reset_mid_drain();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Sits directly downstream of the single-cycle MIPS core top level. Consumes the core's per-cycle observation outputs: pc, inst, WD3, ALUresult, WriteDataMem and the control strobes.
- Each retiring instruction becomes a trace record. Records are buffered in a FIFO and drained through a valid/ready port, so the bench or an off-chip logger can check execution without probing core internals.
- Also keeps a retired-instruction counter and a dropped-record counter.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
FILTER_DEFAULT, 0, value of filter mode after reset: 0 = record every instruction, 1 = record only RegWrite/MemWrite/control-transfer instructions.

Ports:
CLK  input  1  core clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high; clears all state immediately.
enable  input  1  capture enable; when 0, no records are pushed and retired_cnt holds.
filter  input  1  XORed with FILTER_DEFAULT to give the effective filter mode.
pc  input  32  PC of the retiring instruction.
inst  input  32  instruction word.
WD3  input  32  register-file write data.
ALUresult  input  32  ALU result, used as the memory address on stores.
WriteDataMem  input  32  store data.
RegWrite, MemWrite, BEQ, BNE, zero, jump, JR, JAL  input  1 each  core strobes.
out_valid  output  1  head record available.
out_ready  input  1  consumer accepts the head record.
out_pc  output  32  head record: PC.
out_inst  output  32  head record: instruction word.
out_addr  output  32  head record: address (ALUresult), stores only, else 0.
out_data  output  32  head record: WriteDataMem for stores, WD3 for register writes, else 0.
out_kind  output  2  0 = plain, 1 = reg write, 2 = store, 3 = control transfer.
fill  output  clog2(DEPTH)+1  current occupancy.
overflow  output  1  sticky; set on the first dropped record.
drop_cnt  output  16  dropped records, saturating at 0xFFFF.
retired_cnt  output  32  instructions retired while enabled; wraps.

Behaviour:
- Reset: all outputs are 0 (out_valid, out_* fields, fill, overflow, drop_cnt, retired_cnt). FIFO pointers are cleared. Reset asserted mid-drain discards all contents; no partial record ever appears.
- Retirement: one instruction retires on every rising CLK edge while reset=0 and enable=1. retired_cnt increments by 1 on each such edge and wraps from 0xFFFFFFFF to 0.
- Kind classification, by priority:
  - MemWrite → kind 2.
  - else RegWrite → kind 1 (JAL therefore reports kind 1).
  - else jump | JR | (BEQ & zero) | (BNE & ~zero) → kind 3.
  - else → kind 0.
- Push condition: enable=1 and (effective filter=0 or kind≠0).
- Pop condition: out_valid & out_ready, evaluated at the rising edge.
- Latency: a record pushed at edge N is visible on the out_* ports after edge N when the FIFO was empty. out_* always show the head entry and are registered; no combinational path runs from the inputs to out_*.
- FIFO states, tracked by fill:
  - EMPTY (fill=0): out_valid=0, out_* hold 0. A push moves to PARTIAL, or to FULL when DEPTH=1 is reached.
  - PARTIAL: a push alone gives fill+1; a pop alone gives fill−1; push and pop together leave fill unchanged.
  - FULL (fill=DEPTH):
    - push and pop together: both take effect, fill stays DEPTH, no drop.
    - push without pop: the record is discarded, drop_cnt increments (saturating), overflow is set.
- Pointers wrap modulo DEPTH.
- out_ready while out_valid=0 is ignored.
- overflow and drop_cnt clear only on reset.
- enable deassert while the FIFO is non-empty: draining continues normally.
- Mode switching: filter changes take effect for the record at the next edge.

Test Plan:
- Reset held, then released with enable=1, filter=0, out_ready=1, core issuing addi at pc 0x0, 0x4, 0x8:
  - required: records out_pc 0x0, 0x4, 0x8 in order, each with kind 1 and out_data equal to WD3.
  - required: retired_cnt reaches 3 and fill stays ≤1.
- sw with ALUresult=0x40 and WriteDataMem=0xDEADBEEF, filter=1:
  - required: one record with kind 2, out_addr 0x40, out_data 0xDEADBEEF.
  - required: a following nop produces no record.
- BEQ with zero=0 under filter=1 → no record. BEQ with zero=1 → record kind 3. BNE with zero=0 → record kind 3.
- out_ready=0, DEPTH=8, 11 retirements with filter=0:
  - required: fill=8, drop_cnt=3, overflow=1.
  - required: after raising out_ready, the first 8 records come out in order with none missing.
- FIFO full with push and pop on the same edge → fill stays 8, drop_cnt unchanged, head advances by one record.
- Reset pulsed mid-drain with fill=5 → out_valid=0, fill=0, overflow=0, retired_cnt=0 immediately, before the next clock edge.
